fifo_axis_reader: RTL and testbench

Read-side adapter for the single-clock `sync_fifo`. It drains the FIFO's `rd_en`/`data_out`/`empty` port and presents the words as an AXI-Stream master with full valid/ready handshaking. It hides the FIFO's one-cycle read latency and sustains one beat per clock under continuous `m_axis_tready`. It sits between the command/data FIFOs and the AXIS consumers of the I2C master datapath.

---
 rtl/axis_i2c_pkg.sv | 14 +
 rtl/fifo_skid_buf.sv | 72 +++++++
 rtl/fifo_axis_reader.sv | 77 +++++++
 tb/tb_fifo_axis_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_i2c_pkg.sv
// Shared definitions for the FIFO-to-AXIS adapters of the I2C master datapath.
package axis_i2c_pkg;

    localparam int FIFO_RD_LATENCY = 1;
    localparam int AXIS_DATA_WIDTH = 8;

    // Encoding equals the number of buffered words, so the state doubles as cnt.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer that absorbs the FIFO read latency; head entry is
// always presented on head_data.
module fifo_skid_buf
    import axis_i2c_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            cnt
);

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                // On push with pop the old head leaves and the new word replaces it.
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = S_TWO;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = push_data;
                    else      state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign head_data = head_q;
    assign cnt       = 2'(state_q);

    a_no_overflow: assert property (@(posedge clk) disable iff (arst)
        !(state_q == S_TWO && push && !pop));

endmodule

// File: rtl/fifo_axis_reader.sv
// sync_fifo read port to AXI-Stream master adapter. Define FIFO_AXIS_TLAST_EN
// to generate tlast every PACKET_LEN beats; otherwise tlast is tied low.
module fifo_axis_reader
    import axis_i2c_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int PACKET_LEN = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            level
);

    logic       inflight_q, inflight_d;
    logic [1:0] cnt;
    logic       pop;
    logic [2:0] occ;

    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = (cnt != 2'd0);
    assign level         = cnt;

    // Words owned after this edge: buffered plus in flight, less the one leaving.
    always_comb begin
        occ        = {1'b0, cnt} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !fifo_empty && (occ < 3'd2);
        inflight_d = fifo_rd_en;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) inflight_q <= 1'b0;
        else      inflight_q <= inflight_d;
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .arst      (arst),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (m_axis_tdata),
        .cnt       (cnt)
    );

`ifdef FIFO_AXIS_TLAST_EN
    localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_LEN - 1);

    logic [BW-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) beat_q <= '0;
        else      beat_q <= beat_d;
    end

    assign m_axis_tlast = m_axis_tvalid && (beat_q == LAST_BEAT);
`else
    assign m_axis_tlast = 1'b0;
`endif

    a_pkt_len: assert property (@(posedge clk) PACKET_LEN >= 1);

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: FIFO model feeding the DUT, word-ownership model of
// the adapter, directed scenarios plus randomized traffic and resets.
module tb_fifo_axis_reader;

    localparam int DW   = 8;
    localparam int PLEN = 3;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [1:0]    level;

    always #5 clk = ~clk;

    fifo_axis_reader #(.DATA_WIDTH(DW), .PACKET_LEN(PLEN)) dut (
        .clk           (clk),
        .arst          (arst),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .level         (level)
    );

    int checks = 0;
    int errors = 0;

    // fifo_q: words still in the FIFO. exp_q: words taken from the FIFO and not
    // yet delivered, oldest first (the last one may still be in flight).
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            pend = 1'b0;
    int            beats = 0;
    int            pops_total = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          last_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int lvl;
        bit v, p, exp_rd, exp_last;
        lvl    = exp_q.size() - int'(pend);
        v      = (lvl > 0);
        p      = v && m_axis_tready;
        exp_rd = !fifo_empty && (arst || (exp_q.size() - int'(p)) < 2);
`ifdef FIFO_AXIS_TLAST_EN
        exp_last = v && ((beats % PLEN) == PLEN - 1);
`else
        exp_last = 1'b0;
`endif
        chk("level", 32'(level), 32'(lvl));
        chk("tvalid", 32'(m_axis_tvalid), 32'(v));
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("tlast", 32'(m_axis_tlast), 32'(exp_last));
        if (v) chk("tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
        if (arst) chk("tdata_rst", 32'(m_axis_tdata), 32'd0);
        if (prev_stall && !arst) begin
            chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
            chk("hold_data", 32'(m_axis_tdata), 32'(prev_data));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
    endtask

    task automatic settle();
        fifo_empty = (fifo_q.size() == 0);
        #1;
        compare();
    endtask

    task automatic tick();
        bit do_rd, do_pop, lst;
        logic [DW-1:0] w;
        do_rd  = fifo_rd_en && !fifo_empty && !arst;
        do_pop = m_axis_tvalid && m_axis_tready && !arst;
        lst    = m_axis_tlast;
        @(posedge clk);
        #1;
        if (do_pop) begin
            w = exp_q.pop_front();
            beats++;
            pops_total++;
            last_log.push_back(lst);
        end
        if (do_rd) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w);
            fifo_data = w;
        end
        pend = do_rd;
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    // Called at a falling edge; asserts reset mid-cycle and holds it.
    task automatic pulse_reset(input int n);
        #2 arst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_async_level", 32'(level), 32'd0);
        exp_q.delete();
        pend       = 1'b0;
        beats      = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        repeat (n) cyc();
        arst = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    endtask

    initial begin
        int p0;
        bit found;

        // Reset state, FIFO empty
        @(negedge clk);
        settle();
        chk("rst_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        tick();
        cyc();
        arst = 1'b0;

        // Latency and full throughput: 0x11..0x44
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_axis_tready = 1'b1;
        settle();
        chk("lat_c0_valid", 32'(m_axis_tvalid), 32'd0);
        chk("lat_c0_rd", 32'(fifo_rd_en), 32'd1);
        tick();
        settle();
        chk("lat_c1_valid", 32'(m_axis_tvalid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("stream_valid", 32'(m_axis_tvalid), 32'd1);
            chk("stream_data", 32'(m_axis_tdata), 32'(8'h11 * (k + 1)));
            tick();
        end
        settle();
        chk("stream_end_valid", 32'(m_axis_tvalid), 32'd0);
        chk("stream_end_rd", 32'(fifo_rd_en), 32'd0);
        tick();

        // Backpressure: 6 words, tready low
        m_axis_tready = 1'b0;
        load(8'h60, 6);
        repeat (6) cyc();
        settle();
        chk("bp_level", 32'(level), 32'd2);
        chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("bp_tdata", 32'(m_axis_tdata), 32'h60);
        tick();
        m_axis_tready = 1'b1;
        p0 = pops_total;
        repeat (10) cyc();
        chk("bp_drained", 32'(pops_total - p0), 32'd6);

        // Alternating tready with 8 words
        load(8'h80, 8);
        p0 = pops_total;
        for (int i = 0; i < 24; i++) begin
            m_axis_tready = (i % 2 == 0);
            cyc();
        end
        m_axis_tready = 1'b1;
        repeat (6) cyc();
        chk("toggle_count", 32'(pops_total - p0), 32'd8);

        // Reset with data buffered and a read in flight
        m_axis_tready = 1'b0;
        load(8'hA0, 6);
        repeat (4) cyc();
        settle();
        chk("pre_rst_level", 32'(level), 32'd2);
        tick();
        m_axis_tready = 1'b1;
        cyc();
        m_axis_tready = 1'b0;
        pulse_reset(2);
        m_axis_tready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            settle();
            if (m_axis_tvalid) begin
                found = 1'b1;
                chk("restart_data", 32'(m_axis_tdata), 32'hA3);
            end
            tick();
        end
        if (!found) chk("restart_timeout", 32'd0, 32'd1);
        repeat (6) cyc();

`ifdef FIFO_AXIS_TLAST_EN
        // Packet boundaries with PACKET_LEN 3, stalls around the boundary
        pulse_reset(1);
        last_log.delete();
        load(8'hC0, 7);
        for (int i = 0; i < 30; i++) begin
            m_axis_tready = !(i == 4 || i == 5 || i == 9 || i == 12);
            cyc();
        end
        chk("tlast_beats", 32'(last_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < last_log.size(); i++)
            chk("tlast_beat", 32'(last_log[i]), 32'(i == 2 || i == 5));
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 35 && fifo_q.size() < 16)
                fifo_q.push_back(DW'($urandom));
            m_axis_tready = (i / 200) % 3 == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) pulse_reset(1);
            else cyc();
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 60; i++) cyc();
        chk("final_empty", 32'(exp_q.size() + fifo_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
